// File: rtl/hex_cla_accumulator_if.sv
// Operand/result bundle for hex_cla_accumulator.
// Handshake: an operand transfer happens on the rising clock edge where
// in_valid && in_ready are both high; the master must hold op_a/op_b/cin/mode
// stable while in_valid is high and in_ready is low. in_ready never depends
// on in_valid. out_valid is a one-cycle strobe with no back-pressure; sum,
// cout and seg_out stay valid until the next strobe.
interface hex_cla_accumulator_if #(
  parameter int WIDTH = 8
);
  localparam int D = WIDTH / 4;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 cin;
  logic                 mode;
  logic                 clear;
  logic                 out_valid;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [7*(D+1)-1:0]   seg_out;

  modport master (
    output in_valid, op_a, op_b, cin, mode, clear,
    input  in_ready, out_valid, sum, cout, seg_out
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, mode, clear,
    output in_ready, out_valid, sum, cout, seg_out
  );
endinterface

// File: rtl/hex_cla_accumulator.sv
// Multi-cycle nibble-serial carry look-ahead adder/accumulator.
// One 4-bit CLA slice is evaluated per clock, LSB nibble first. The result
// drives one active-low 7-segment digit per nibble plus a carry digit.
// Optional feature macro: HEX_LZ_BLANK_EN (blank leading-zero digits and a
// zero carry digit).
module hex_cla_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hex_cla_accumulator_if.slave bus,
  output logic [1:0]           dbg_state_o,
  output logic [WIDTH-1:0]     dbg_acc_o
);

  localparam int D    = WIDTH / 4;
  localparam int IDXW = (D > 1) ? $clog2(D) : 1;
  localparam int SEGW = 7 * (D + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              mode_q, mode_d;
  logic              c_q, c_d;
  logic              cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [SEGW-1:0]   seg_q, seg_d;

  logic              ready_w;
  logic [3:0]        sl_a, sl_b, sl_g, sl_p, sl_s;
  logic [4:0]        sl_c;

  // Active-low hex glyph, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Full display image for a result: D sum digits plus the carry digit on top.
  function automatic logic [SEGW-1:0] encode(input logic [WIDTH-1:0] s,
                                             input logic co);
    logic [SEGW-1:0] r;
`ifdef HEX_LZ_BLANK_EN
    logic            seen;
`endif
    r = '0;
`ifdef HEX_LZ_BLANK_EN
    // Walk from the top nibble down; a digit is shown once any nibble at or
    // above it is nonzero. Digit 0 is always shown.
    seen = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      seen = seen | (s[4*k +: 4] != 4'h0) | (k == 0);
      r[7*k +: 7] = seen ? glyph(s[4*k +: 4]) : 7'b1111111;
    end
    r[7*D +: 7] = co ? glyph(4'h1) : 7'b1111111;
`else
    for (int k = 0; k < D; k++) begin
      r[7*k +: 7] = glyph(s[4*k +: 4]);
    end
    r[7*D +: 7] = glyph({3'b000, co});
`endif
    return r;
  endfunction

  // One CLA slice on the nibble selected by idx; carries all derived from g/p/c.
  always_comb begin
    sl_a    = a_q[{idx_q, 2'b00} +: 4];
    sl_b    = b_q[{idx_q, 2'b00} +: 4];
    sl_g    = sl_a & sl_b;
    sl_p    = sl_a ^ sl_b;
    sl_c[0] = c_q;
    sl_c[1] = sl_g[0] | (sl_p[0] & c_q);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & c_q);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & c_q);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & c_q);
    sl_s    = sl_p ^ sl_c[3:0];
  end

  // clear in IDLE wins over a simultaneous in_valid by dropping ready.
  assign ready_w = (state_q == IDLE) && !bus.clear;

  // Next-state and datapath updates for IDLE -> CALC (D cycles) -> DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    c_d     = c_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          acc_d = '0;
        end else if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.mode ? acc_q : bus.op_b;
          c_d     = bus.cin;
          mode_d  = bus.mode;
          idx_d   = '0;
          res_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[{idx_q, 2'b00} +: 4] = sl_s;
        c_d = sl_c[4];
        if (idx_q == IDXW'(D - 1)) begin
          // Last slice: publish the result so it is visible during DONE.
          sum_d   = res_d;
          cout_d  = sl_c[4];
          seg_d   = encode(res_d, sl_c[4]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        // Running total wraps; the carry out is never folded back in.
        if (mode_q) begin
          acc_d = sum_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      seg_q   <= encode('0, 1'b0);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.in_ready  = ready_w;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.seg_out   = seg_q;
  assign dbg_state_o   = state_q;
  assign dbg_acc_o     = acc_q;

endmodule

// File: tb/tb_hex_cla_accumulator.sv
// Self-checking bench for hex_cla_accumulator (WIDTH=8): table vectors,
// directed multi-cycle sequences and randomized operations against a
// cycle-level reference model of the handshake and arithmetic.
module tb_hex_cla_accumulator;
  localparam int W    = 8;
  localparam int D    = W / 4;
  localparam int SEGW = 7 * (D + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_cla_accumulator_if #(.WIDTH(W)) bus ();
  logic [1:0]   dbg_state;
  logic [W-1:0] dbg_acc;

  hex_cla_accumulator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_acc_o   (dbg_acc)
  );

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;

  logic [6:0] glyph_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display expected for a value, derived digit by digit from the value.
  function automatic logic [SEGW-1:0] model_seg(input logic [W-1:0] s, input logic co);
    logic [SEGW-1:0] r;
    logic [3:0]      nib;
    r = '0;
    for (int k = 0; k < D; k++) begin
      nib = 4'((s >> (4 * k)) & W'(15));
      r[7*k +: 7] = glyph_tbl[nib];
`ifdef HEX_LZ_BLANK_EN
      if (k > 0 && (s >> (4 * k)) == 0) r[7*k +: 7] = 7'b1111111;
`endif
    end
    r[7*D +: 7] = co ? glyph_tbl[1] : glyph_tbl[0];
`ifdef HEX_LZ_BLANK_EN
    if (!co) r[7*D +: 7] = 7'b1111111;
`endif
    return r;
  endfunction

  // ---------------- reference model ----------------
  // busy counts cycles until the unit accepts again; busy==1 is the result cycle.
  logic [W:0]   exp_q[$];
  int           m_busy = 0;
  logic [W-1:0] m_acc  = '0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W:0]   t;
    logic [W-1:0] src_b;
    if (rst) begin
      m_busy = 0;
      m_acc  = '0;
      m_sum  = '0;
      m_cout = 1'b0;
      exp_q.delete();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 1 && exp_q.size() > 0) begin
        t = exp_q.pop_front();
        m_cout = t[W];
        m_sum  = t[W-1:0];
      end
    end else if (bus.clear) begin
      m_acc = '0;
    end else if (bus.in_valid) begin
      src_b = bus.mode ? m_acc : bus.op_b;
      t = {1'b0, bus.op_a} + {1'b0, src_b} + (W + 1)'(bus.cin);
      exp_q.push_back(t);
      if (bus.mode) m_acc = t[W-1:0];
      m_busy = D + 1;
    end
  end

  // ---------------- scoreboard monitor (opposite edge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, (m_busy == 0) && !bus.clear);
      check("out_valid", bus.out_valid, m_busy == 1);
      check("sum", bus.sum, m_sum);
      check("cout", bus.cout, m_cout);
      check("seg_out", bus.seg_out, model_seg(m_sum, m_cout));
      if (m_busy == 0) check("acc", dbg_acc, m_acc);
      if (bus.out_valid) ov_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 0 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles", m_busy, n);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic md);
    wait_idle();
    bus.op_a = a; bus.op_b = b; bus.cin = ci; bus.mode = md;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear(input logic with_valid);
    bus.clear = 1'b1; bus.in_valid = with_valid;
    tick();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t tbl[8];
  logic ov_seq [1:4];
  logic rdy_seq[1:4];
  int   ov0;

  // ---------------- stimulus ----------------
  initial begin
    tbl[0] = '{8'h5A, 8'hC3, 1'b0, 8'h1D, 1'b1};
    tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h05, 8'h00, 1'b0, 8'h05, 1'b0};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.cin = 1'b0; bus.mode = 1'b0; bus.clear = 1'b0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_sum", bus.sum, 8'h00);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_acc", dbg_acc, 8'h00);
`ifdef HEX_LZ_BLANK_EN
    check("rst_seg", bus.seg_out, {7'b1111111, 7'b1111111, 7'b1000000});
`else
    check("rst_seg", bus.seg_out, {7'b1000000, 7'b1000000, 7'b1000000});
`endif

    // Table vectors (mode 0)
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0);
      wait_idle();
      check($sformatf("vec%0d_sum", i), bus.sum, tbl[i].es);
      check($sformatf("vec%0d_cout", i), bus.cout, tbl[i].ec);
    end

    // Exact latency, in_ready low window, operands changed during CALC
    wait_idle();
    bus.op_a = 8'h5A; bus.op_b = 8'hC3; bus.cin = 1'b0; bus.mode = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ov_seq[i]  = bus.out_valid;
      rdy_seq[i] = bus.in_ready;
      if (i == 3) begin
        check("lat_sum", bus.sum, 8'h1D);
        check("lat_cout", bus.cout, 1'b1);
        check("lat_seg", bus.seg_out, {7'b1111001, 7'b1111001, 7'b0100001});
      end
      bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.cin = 1'($urandom);
      if (i < 4) tick();
    end
    check("lat_out_valid", {ov_seq[1], ov_seq[2], ov_seq[3], ov_seq[4]}, 4'b0010);
    check("lat_in_ready", {rdy_seq[1], rdy_seq[2], rdy_seq[3], rdy_seq[4]}, 4'b0001);
    tick();
    check("lat_hold_sum", bus.sum, 8'h1D);

    // Accumulate: clear, then 0xFF twice
    wait_idle();
    pulse_clear(1'b0);
    check("clr_acc", dbg_acc, 8'h00);
    send(8'hFF, 8'h12, 1'b0, 1'b1);
    wait_idle();
    check("acc1_sum", bus.sum, 8'hFF);
    check("acc1_cout", bus.cout, 1'b0);
    send(8'hFF, 8'h34, 1'b0, 1'b1);
    wait_idle();
    check("acc2_sum", bus.sum, 8'hFE);
    check("acc2_cout", bus.cout, 1'b1);
    check("acc2_acc", dbg_acc, 8'hFE);

    // clear together with in_valid: no transfer, acc cleared
    ov0 = ov_cnt;
    bus.op_a = 8'h11; bus.op_b = 8'h22; bus.mode = 1'b0;
    bus.clear = 1'b1; bus.in_valid = 1'b1;
    tick();
    check("clrv_in_ready", bus.in_ready, 1'b0);
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    repeat (5) tick();
    check("clrv_acc", dbg_acc, 8'h00);
    check("clrv_no_result", ov_cnt - ov0, 0);

    // Back-to-back with in_valid held high and operands changing every cycle
    wait_idle();
    ov0 = ov_cnt;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.op_a = W'($urandom); bus.op_b = W'($urandom);
      bus.cin = 1'($urandom); bus.mode = 1'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_idle();
    tick();
    check("b2b_results", ov_cnt - ov0, 10);

    // Reset mid-CALC
    wait_idle();
    pulse_clear(1'b0);
    send(8'h42, 8'h00, 1'b0, 1'b1);
    wait_idle();
    check("pre_rst_acc", dbg_acc, 8'h42);
    send(8'h10, 8'h00, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("rstc_out_valid", bus.out_valid, 1'b0);
    check("rstc_sum", bus.sum, 8'h00);
    check("rstc_cout", bus.cout, 1'b0);
    check("rstc_acc", dbg_acc, 8'h00);
    check("rstc_in_ready", bus.in_ready, 1'b1);
    tick();
    rst = 1'b0;
    ov0 = ov_cnt;
    repeat (5) tick();
    check("rstc_no_result", ov_cnt - ov0, 0);

    // Reset during DONE
    send(8'h21, 8'h00, 1'b0, 1'b1);
    tick(); tick();
    check("done_out_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rstd_out_valid", bus.out_valid, 1'b0);
    check("rstd_sum", bus.sum, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    check("rstd_acc", dbg_acc, 8'h00);

    // Leading-zero display behaviour
    send(8'h05, 8'h00, 1'b0, 1'b0);
    wait_idle();
`ifdef HEX_LZ_BLANK_EN
    check("lz_digit1", bus.seg_out[13:7], 7'b1111111);
    check("lz_carry", bus.seg_out[20:14], 7'b1111111);
`else
    check("lz_digit1", bus.seg_out[13:7], 7'b1000000);
    check("lz_carry", bus.seg_out[20:14], 7'b1000000);
`endif
    check("lz_digit0", bus.seg_out[6:0], 7'b0010010);

    // Randomized operations, occasional clears and idle gaps
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_clear(1'($urandom));
      end else begin
        send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    tick();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
